alu_bist: RTL

- Synthesisable, parametrised built-in self-test engine for the datapath ALU.
- Fetches packed test vectors from a synchronous vector ROM and drives the ALU under test.
- Compares both result and the 4-bit NZCV flags against expected values, then reports pass/fail, error count and first failing index.
- Sits beside the ALU in the processor datapath and gives the processor-level bench a hardware self-check replacing file-driven checking.

---
 rtl/alu_bist.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_bist.sv
// Built-in self-test engine for the datapath ALU.
// Reads packed vectors from a synchronous ROM, applies them, and checks the result and NZCV flags.
module alu_bist #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 16,
    parameter int CHECK_FLAGS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop_on_error,
    input  logic [ADDR_W:0]      num_vectors,
    output logic [ADDR_W-1:0]    vec_addr,
    input  logic [3*WIDTH+5:0]   vec_data,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [3:0]           alu_flags,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     error_count,
    output logic                 fail_valid,
    output logic [ADDR_W-1:0]    fail_index
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // FETCH | vec_addr holds idx, ROM read in flight
    // APPLY | vec_data valid, captured into ALU drive and expected registers
    // CHECK | ALU output compared against expected values
    // DONE  | run finished, status held until next start
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    localparam bit              FLAG_EN = (CHECK_FLAGS != 0);
    localparam logic [ADDR_W:0] MAX_VEC = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    state_t              state_nx;
    logic                start_run;
    logic [ADDR_W:0]     count_in;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   idx;
    logic                stop_latched;
    logic [WIDTH-1:0]    exp_result;
    logic [3:0]          exp_flags;
    logic                mismatch;
    logic                last;

    assign count_in = (num_vectors > MAX_VEC) ? MAX_VEC : num_vectors;
    assign mismatch = (alu_result != exp_result) | (FLAG_EN & (alu_flags != exp_flags));
    assign last     = ({1'b0, idx} == (count - 1'b1));

    assign busy = (state == S_FETCH) || (state == S_APPLY) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (error_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        start_run = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nx  = (count_in == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nx = S_APPLY;
            S_APPLY: state_nx = S_CHECK;
            S_CHECK: begin
                if (last || (stop_latched && mismatch)) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            idx          <= '0;
            stop_latched <= 1'b0;
            vec_addr     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            exp_result   <= '0;
            exp_flags    <= '0;
            error_count  <= '0;
            fail_valid   <= 1'b0;
            fail_index   <= '0;
        end else begin
            if (start_run) begin
                count        <= count_in;
                stop_latched <= stop_on_error;
                error_count  <= '0;
                fail_valid   <= 1'b0;
                fail_index   <= '0;
                idx          <= '0;
                // An empty run leaves the ROM address where the last run left it
                if (count_in != '0) begin
                    vec_addr <= '0;
                end
            end
            if (state == S_APPLY) begin
                alu_control <= vec_data[3*WIDTH+5:3*WIDTH+4];
                alu_a       <= vec_data[3*WIDTH+3:2*WIDTH+4];
                alu_b       <= vec_data[2*WIDTH+3:WIDTH+4];
                exp_result  <= vec_data[WIDTH+3:4];
                exp_flags   <= vec_data[3:0];
            end
            if (state == S_CHECK) begin
                if (mismatch) begin
                    if (error_count != '1) begin
                        error_count <= error_count + 1'b1;
                    end
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_index <= idx;
                    end
                end
                // Address is advanced here so the ROM read overlaps the FETCH cycle
                if (state_nx == S_FETCH) begin
                    idx      <= idx + 1'b1;
                    vec_addr <= idx + 1'b1;
                end
            end
        end
    end

endmodule
